mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port between demand accesses from the CPU and requests from the stride prefetcher. Prefetch requests are buffered in a small queue. Duplicates of queued or in-flight addresses are filtered out. Demand traffic has priority, and a starvation counter guarantees prefetch forward progress. Issued requests are tracked in order so that responses are steered back to the correct requester.

## Interface
Parameters:
- ADDR_W, 16, address width
- PQ_DEPTH, 4, prefetch queue entries (power of 2)
- MAX_OUT, 4, maximum outstanding memory requests (power of 2)
- STARVE_LIM, 8, consecutive demand grants allowed while the prefetch queue is non-empty, before a prefetch is forced

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- dem_valid  in  1  CPU demand request
- dem_addr  in  ADDR_W  demand address
- dem_ready  out  1  demand accepted this cycle
- dem_resp_valid  out  1  response for oldest outstanding demand
- pf_valid  in  1  prefetch request pulse; no backpressure
- pf_addr  in  ADDR_W  prefetch address
- pf_drop  out  1  pulse: prefetch request discarded
- pf_fill  out  1  pulse: prefetch response absorbed
- mem_req_valid  out  1  request to memory
- mem_req_addr  out  ADDR_W  request address
- mem_req_is_pf  out  1  request originates from the prefetch queue
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  in-order response from memory
- pq_count  out  $clog2(PQ_DEPTH)+1  valid entries in the prefetch queue

## Operation
Prefetch queue (PQ)
- FIFO of {valid, addr}.
- On pf_valid, the request is enqueued unless one of the following holds, in which case pf_drop=1 that cycle:
  - the PQ is full;
  - pf_addr matches a valid PQ entry;
  - pf_addr matches an outstanding tracked address;
  - pf_addr matches a demand issued in the same cycle.

Squash
- A demand issue to address A clears the valid bit of every PQ entry with address A.
- When the head entry is invalid, it is popped with no memory request. This takes one cycle and is not counted as a grant.

Arbitration (combinational each cycle)
- can_issue = outstanding < MAX_OUT.
- pf_pick = PQ head valid && (!dem_valid || starve_cnt == STARVE_LIM).
- mem_req_valid = can_issue && (dem_valid || PQ head valid).
- Address and is_pf follow the pick.
- dem_ready = mem_req_valid && !pf_pick && mem_req_ready.
- Issue = mem_req_valid && mem_req_ready.

Starvation counter
- Increments on each demand issue while the PQ is non-empty.
- Resets to 0 on a prefetch issue or when the PQ is empty.
- Saturates at STARVE_LIM.

Outstanding tracker
- In-order FIFO of {is_pf, addr}, depth MAX_OUT.
- Push on issue; pop on mem_resp_valid.
- Popped is_pf=0 gives dem_resp_valid=1; is_pf=1 gives pf_fill=1.
- mem_resp_valid while the tracker is empty is ignored. This is an error case and raises an assertion in simulation.

## Timing
- Reset values: every output is 0. PQ and tracker are empty, starve_cnt=0.
- Demand path: dem_valid to mem_req_valid is combinational (0 cycles). dem_ready is in the same cycle.
- Prefetch path: pf_valid at cycle t is enqueued at posedge t+1. The earliest it can issue is cycle t+1.
- Responses: dem_resp_valid/pf_fill are combinational from mem_resp_valid.
- Issue and response in the same cycle: outstanding is unchanged, so a full tracker can still issue.
- Enqueue and pop/squash-pop of the PQ in the same cycle: the count is unchanged.
- PQ full with an issue in the same cycle: the incoming request is still dropped. The full check uses the registered count.
- mem_req_ready=0: no state changes except PQ enqueue, and dem_ready=0.
  - Requesters may change their request.
  - The arbiter re-evaluates every cycle; there is no request hold requirement.
- Reset mid-operation: all queues are flushed next edge. Outstanding responses arriving after reset are ignored.

## Structure
- Package mem_arb_pkg:
  - ADDR_W default;
  - typedef req_src_e {SRC_DEM, SRC_PF};
  - typedef pq_entry_t {valid, addr};
  - typedef trk_entry_t {src, addr}.
- Sub-module arb_fifo: a parameterised synchronous FIFO with occupancy count and parallel entry read-out for compare. It is instantiated for the PQ and the tracker.
- Compare and squash logic stays in the top level.

## Test plan
- Reset, then pf_valid with addresses 0x0010, 0x0020, 0x0030 and no demand:
  - three issues with is_pf=1 in order;
  - three mem_resp_valid give three pf_fill pulses and no dem_resp_valid.
- PQ holds 0x0040; inject pf 0x0040 again:
  - pf_drop=1 and pq_count stays 1.
  - Issue 0x0040 and re-inject it while it is outstanding: pf_drop=1.
- Continuous dem_valid (addresses 0x1000+) with PQ holding 0x0050 and STARVE_LIM=8:
  - exactly 8 demand issues, then 0x0050 issues with is_pf=1, then demand resumes.
- PQ holds 0x0060, 0x0070; demand issues 0x0060:
  - the head is squashed and popped without issue;
  - the next prefetch issued is 0x0070.
- Fill the tracker to MAX_OUT=4 with mem_resp_valid low:
  - mem_req_valid=0 and dem_ready=0.
  - Assert mem_resp_valid and dem_valid together: the issue occurs the same cycle and outstanding stays 4.
- Assert reset with 3 outstanding and PQ=2:
  - next cycle all outputs are 0 and pq_count=0;
  - a following mem_resp_valid produces no dem_resp_valid or pf_fill.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: request source tag, the
// prefetch-queue entry and the outstanding-tracker entry.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 16;

    typedef enum logic {
        SRC_DEM = 1'b0,
        SRC_PF  = 1'b1
    } req_src_e;

    // A cleared valid bit marks a squashed entry that is popped without issue.
    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
    } pq_entry_t;

    typedef struct packed {
        req_src_e              src;
        logic [DEF_ADDR_W-1:0] addr;
    } trk_entry_t;

endpackage

// File: rtl/arb_fifo.sv
// Synchronous FIFO with occupancy count and a parallel view of every slot
// in logical order (index 0 is the head), used for address compares.
// clrMask zeroes live entries in place, addressed by logical index.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             pushData,
    input  logic                         pop,
    input  logic [DEPTH-1:0]             clrMask,
    output logic [WIDTH-1:0]             headData,
    output logic [$clog2(DEPTH):0]       count,
    output logic [DEPTH-1:0][WIDTH-1:0]  entries,
    output logic [DEPTH-1:0]             live
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wrPtr;
    logic [PW-1:0]               rdPtr;
    logic                        doPush;
    logic                        doPop;

    // Accept/pop qualification and the logical-order read-out.
    always_comb begin
        doPop    = pop && (count != '0);
        doPush   = push && ((count != CW'(DEPTH)) || doPop);
        headData = mem[rdPtr];
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem[rdPtr + PW'(i)];
            live[i]    = CW'(i) < count;
        end
    end

    // Storage, pointers and occupancy; a write in the same cycle wins over a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem   <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clrMask[i] && live[i]) begin
                    mem[rdPtr + PW'(i)] <= '0;
                end
            end
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between CPU demand accesses and queued
// stride prefetches. Demand wins unless the starvation counter has reached
// its limit; duplicate prefetches are filtered; issued requests are tracked
// in order so responses are steered back to their requester.
//
// Handshake: a request transfers on a cycle where mem_req_valid and
// mem_req_ready are both high; valid may drop or change without a transfer,
// since the pick is re-evaluated every cycle. dem_ready is high exactly on
// cycles where the demand request transfers. pf_valid has no backpressure:
// each pulse is either queued or reported on pf_drop in that same cycle.
//
// ADDR_W must match the package DEF_ADDR_W, which sizes the entry structs.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int PQ_DEPTH   = 4,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dem_valid,
    input  logic [ADDR_W-1:0]           dem_addr,
    output logic                        dem_ready,
    output logic                        dem_resp_valid,
    input  logic                        pf_valid,
    input  logic [ADDR_W-1:0]           pf_addr,
    output logic                        pf_drop,
    output logic                        pf_fill,
    output logic                        mem_req_valid,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic                        mem_req_is_pf,
    input  logic                        mem_req_ready,
    input  logic                        mem_resp_valid,
    output logic [$clog2(PQ_DEPTH):0]   pq_count
);

    localparam int PQ_W   = $bits(pq_entry_t);
    localparam int TRK_W  = $bits(trk_entry_t);
    localparam int PQ_CW  = $clog2(PQ_DEPTH) + 1;
    localparam int TRK_CW = $clog2(MAX_OUT) + 1;
    localparam int SC_W   = $clog2(STARVE_LIM + 1);

    logic [PQ_DEPTH-1:0][PQ_W-1:0]  pqRaw;
    logic [PQ_DEPTH-1:0]            pqLive;
    logic [PQ_DEPTH-1:0]            pqClr;
    logic [PQ_CW-1:0]               pqCount;
    logic [PQ_W-1:0]                pqHeadRaw;
    logic                           pqPush;
    logic                           pqPop;
    pq_entry_t                      pqEnt [PQ_DEPTH];
    pq_entry_t                      pqHead;
    pq_entry_t                      pqPushEnt;

    logic [MAX_OUT-1:0][TRK_W-1:0]  trkRaw;
    logic [MAX_OUT-1:0]             trkLive;
    logic [TRK_CW-1:0]              trkCount;
    logic [TRK_W-1:0]               trkHeadRaw;
    logic                           trkPush;
    logic                           trkPop;
    trk_entry_t                     trkEnt [MAX_OUT];
    trk_entry_t                     trkHead;
    trk_entry_t                     trkPushEnt;

    logic [SC_W-1:0]                starveCnt;
    logic [TRK_CW-1:0]              ghostCnt;
    logic                           headValid;
    logic                           headStale;
    logic                           canIssue;
    logic                           pfPick;
    logic                           issue;
    logic                           demIssue;
    logic                           pfIssue;
    logic                           pqFull;
    logic                           hitPq;
    logic                           hitTrk;
    logic                           hitDem;

    // Typed views of the FIFO contents.
    always_comb begin
        pqHead  = pqHeadRaw;
        trkHead = trkHeadRaw;
        for (int i = 0; i < PQ_DEPTH; i++) begin
            pqEnt[i] = pqRaw[i];
        end
        for (int j = 0; j < MAX_OUT; j++) begin
            trkEnt[j] = trkRaw[j];
        end
    end

    // Port arbitration: demand first, prefetch when idle or when starved.
    // A response in the same cycle frees a tracker slot, so a full tracker can still issue.
    always_comb begin
        headValid     = (pqCount != '0) && pqHead.valid;
        headStale     = (pqCount != '0) && !pqHead.valid;
        canIssue      = (trkCount < TRK_CW'(MAX_OUT)) || (mem_resp_valid && (trkCount != '0));
        pfPick        = headValid && (!dem_valid || (starveCnt == SC_W'(STARVE_LIM)));
        mem_req_valid = canIssue && (dem_valid || headValid);
        mem_req_is_pf = mem_req_valid && pfPick;
        mem_req_addr  = '0;
        if (mem_req_valid) begin
            mem_req_addr = pfPick ? pqHead.addr : dem_addr;
        end
        dem_ready     = mem_req_valid && !pfPick && mem_req_ready;
        issue         = mem_req_valid && mem_req_ready;
        demIssue      = dem_ready;
        pfIssue       = issue && pfPick;
        trkPush       = issue;
        trkPushEnt    = '{src: (pfPick ? SRC_PF : SRC_DEM), addr: mem_req_addr};
    end

    // Duplicate filter, squash of queued copies of an issuing demand, and PQ push/pop.
    // The full check uses the registered count, so a pop this cycle does not make room.
    always_comb begin
        hitPq  = 1'b0;
        hitTrk = 1'b0;
        pqClr  = '0;
        for (int i = 0; i < PQ_DEPTH; i++) begin
            if (pqLive[i] && pqEnt[i].valid) begin
                if (pqEnt[i].addr == pf_addr) begin
                    hitPq = 1'b1;
                end
                if (demIssue && (pqEnt[i].addr == dem_addr)) begin
                    pqClr[i] = 1'b1;
                end
            end
        end
        for (int j = 0; j < MAX_OUT; j++) begin
            if (trkLive[j] && (trkEnt[j].addr == pf_addr)) begin
                hitTrk = 1'b1;
            end
        end
        hitDem    = demIssue && (dem_addr == pf_addr);
        pqFull    = pqCount == PQ_CW'(PQ_DEPTH);
        pf_drop   = pf_valid && (pqFull || hitPq || hitTrk || hitDem);
        pqPush    = pf_valid && !pf_drop;
        pqPushEnt = '{valid: 1'b1, addr: pf_addr};
        // A stale head is dropped in its own cycle; it holds while the port is stalled.
        pqPop     = pfIssue || (headStale && mem_req_ready);
        pq_count  = pqCount;
    end

    // Response steering from the oldest tracked request.
    always_comb begin
        trkPop         = mem_resp_valid && (trkCount != '0);
        dem_resp_valid = trkPop && (trkHead.src == SRC_DEM);
        pf_fill        = trkPop && (trkHead.src == SRC_PF);
    end

    // Starvation counter: counts demand grants taken while a prefetch waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            starveCnt <= '0;
        end else if (pfIssue || (pqCount == '0)) begin
            starveCnt <= '0;
        end else if (demIssue && (starveCnt != SC_W'(STARVE_LIM))) begin
            starveCnt <= starveCnt + SC_W'(1);
        end
    end

    // Responses owed to requests flushed by reset; only the check below reads this.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (trkCount != '0) begin
                ghostCnt <= trkCount;
            end
        end else if (mem_resp_valid && (trkCount == '0) && (ghostCnt != '0)) begin
            ghostCnt <= ghostCnt - TRK_CW'(1);
        end
    end

    // Flag a response that matches neither a tracked nor a flushed request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(mem_resp_valid && (trkCount == '0) && (ghostCnt == '0)))
                else $error("mem_port_arbiter: response with no outstanding request");
        end
    end

    arb_fifo #(
        .WIDTH (PQ_W),
        .DEPTH (PQ_DEPTH)
    ) uPq (
        .clk      (clk),
        .reset    (reset),
        .push     (pqPush),
        .pushData (pqPushEnt),
        .pop      (pqPop),
        .clrMask  (pqClr),
        .headData (pqHeadRaw),
        .count    (pqCount),
        .entries  (pqRaw),
        .live     (pqLive)
    );

    arb_fifo #(
        .WIDTH (TRK_W),
        .DEPTH (MAX_OUT)
    ) uTrk (
        .clk      (clk),
        .reset    (reset),
        .push     (trkPush),
        .pushData (trkPushEnt),
        .pop      (trkPop),
        .clrMask  ('0),
        .headData (trkHeadRaw),
        .count    (trkCount),
        .entries  (trkRaw),
        .live     (trkLive)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: prefetch ordering, duplicate filter,
// starvation release, squash, tracker-full back-to-back issue, mid-run reset.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 16;

    logic              clk;
    logic              reset;
    logic              dem_valid;
    logic [ADDR_W-1:0] dem_addr;
    logic              dem_ready;
    logic              dem_resp_valid;
    logic              pf_valid;
    logic [ADDR_W-1:0] pf_addr;
    logic              pf_drop;
    logic              pf_fill;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_is_pf;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [2:0]        pq_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected issue addresses, consumed in order.
    logic [ADDR_W-1:0] exp_q[$];

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .PQ_DEPTH   (4),
        .MAX_OUT    (4),
        .STARVE_LIM (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dem_valid      (dem_valid),
        .dem_addr       (dem_addr),
        .dem_ready      (dem_ready),
        .dem_resp_valid (dem_resp_valid),
        .pf_valid       (pf_valid),
        .pf_addr        (pf_addr),
        .pf_drop        (pf_drop),
        .pf_fill        (pf_fill),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_is_pf  (mem_req_is_pf),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .pq_count       (pq_count)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dem_valid      = 1'b0;
        pf_valid       = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".mem_req_valid"},  mem_req_valid,  0);
        check({tag, ".mem_req_addr"},   mem_req_addr,   0);
        check({tag, ".mem_req_is_pf"},  mem_req_is_pf,  0);
        check({tag, ".dem_ready"},      dem_ready,      0);
        check({tag, ".dem_resp_valid"}, dem_resp_valid, 0);
        check({tag, ".pf_drop"},        pf_drop,        0);
        check({tag, ".pf_fill"},        pf_fill,        0);
        check({tag, ".pq_count"},       pq_count,       0);
    endtask

    task automatic check_pf_issue(input string tag);
        logic [ADDR_W-1:0] e;
        e = exp_q.pop_front();
        check({tag, ".valid"}, mem_req_valid, 1);
        check({tag, ".is_pf"}, mem_req_is_pf, 1);
        check({tag, ".addr"},  mem_req_addr,  e);
    endtask

    initial begin
        reset         = 1'b1;
        dem_addr      = '0;
        pf_addr       = '0;
        mem_req_ready = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        #1;
        check_outputs_zero("reset");

        // Three prefetches, no demand: issue in order, then three fills.
        exp_q.push_back(16'h0010);
        exp_q.push_back(16'h0020);
        exp_q.push_back(16'h0030);
        pf_valid = 1'b1; pf_addr = 16'h0010; #1;
        check("pf1.drop", pf_drop, 0);
        check("pf1.no_req", mem_req_valid, 0);
        step();
        pf_addr = 16'h0020; #1;
        check_pf_issue("pf_issue0");
        check("pf1.count", pq_count, 1);
        step();
        pf_addr = 16'h0030; #1;
        check_pf_issue("pf_issue1");
        step();
        pf_valid = 1'b0; #1;
        check_pf_issue("pf_issue2");
        step();
        #1;
        check("pf1.drained", mem_req_valid, 0);
        check("pf1.count0", pq_count, 0);
        for (int k = 0; k < 3; k++) begin
            mem_resp_valid = 1'b1; #1;
            check("pf1.fill", pf_fill, 1);
            check("pf1.no_dem_resp", dem_resp_valid, 0);
            step();
        end
        mem_resp_valid = 1'b0; #1;
        check("pf1.fill_off", pf_fill, 0);

        // Duplicate filter against the queue and against the tracker.
        mem_req_ready = 1'b0;
        pf_valid = 1'b1; pf_addr = 16'h0040;
        step();
        #1;
        check("dup_pq.drop", pf_drop, 1);
        step();
        pf_valid = 1'b0; #1;
        check("dup_pq.count", pq_count, 1);
        mem_req_ready = 1'b1; #1;
        check("dup.issue_addr", mem_req_addr, 16'h0040);
        check("dup.issue_pf", mem_req_is_pf, 1);
        step();
        pf_valid = 1'b1; pf_addr = 16'h0040; #1;
        check("dup_trk.drop", pf_drop, 1);
        step();
        pf_valid = 1'b0; mem_resp_valid = 1'b1; #1;
        check("dup_trk.count", pq_count, 0);
        check("dup_trk.fill", pf_fill, 1);
        step();
        mem_resp_valid = 1'b0;

        // Starvation: 8 demand grants, then the waiting prefetch, then demand again.
        mem_req_ready = 1'b0;
        pf_valid = 1'b1; pf_addr = 16'h0050;
        step();
        pf_valid = 1'b0;
        mem_req_ready = 1'b1;
        dem_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            dem_addr = ADDR_W'(16'h1000 + k);
            mem_resp_valid = (k != 0);
            #1;
            check("starve.dem_ready", dem_ready, 1);
            check("starve.dem_addr", mem_req_addr, 16'h1000 + k);
            check("starve.dem_not_pf", mem_req_is_pf, 0);
            if (k != 0) check("starve.dem_resp", dem_resp_valid, 1);
            step();
        end
        dem_addr = 16'h1008; mem_resp_valid = 1'b1; #1;
        check("starve.pf_forced", mem_req_is_pf, 1);
        check("starve.pf_addr", mem_req_addr, 16'h0050);
        check("starve.dem_held", dem_ready, 0);
        check("starve.resp_dem", dem_resp_valid, 1);
        step();
        #1;
        check("starve.resume", dem_ready, 1);
        check("starve.resume_addr", mem_req_addr, 16'h1008);
        check("starve.pf_fill", pf_fill, 1);
        check("starve.fill_not_dem", dem_resp_valid, 0);
        step();
        dem_valid = 1'b0; #1;
        check("starve.last_resp", dem_resp_valid, 1);
        step();
        mem_resp_valid = 1'b0;

        // Squash: a demand to the queued head invalidates it; it is popped without issue.
        mem_req_ready = 1'b0;
        pf_valid = 1'b1; pf_addr = 16'h0060;
        step();
        pf_addr = 16'h0070;
        step();
        pf_valid = 1'b0; #1;
        check("squash.count2", pq_count, 2);
        mem_req_ready = 1'b1;
        dem_valid = 1'b1; dem_addr = 16'h0060; #1;
        check("squash.dem_ready", dem_ready, 1);
        check("squash.dem_addr", mem_req_addr, 16'h0060);
        step();
        dem_valid = 1'b0; #1;
        check("squash.no_req", mem_req_valid, 0);
        check("squash.count_hold", pq_count, 2);
        step();
        #1;
        check("squash.next_pf_addr", mem_req_addr, 16'h0070);
        check("squash.next_pf_is_pf", mem_req_is_pf, 1);
        check("squash.count1", pq_count, 1);
        step();
        mem_resp_valid = 1'b1; #1;
        check("squash.resp_dem", dem_resp_valid, 1);
        step();
        #1;
        check("squash.resp_pf", pf_fill, 1);
        step();
        mem_resp_valid = 1'b0;

        // Prefetch matching a demand issued in the same cycle is dropped.
        dem_valid = 1'b1; dem_addr = 16'h0080;
        pf_valid = 1'b1; pf_addr = 16'h0080; #1;
        check("samecyc.dem_ready", dem_ready, 1);
        check("samecyc.drop", pf_drop, 1);
        step();
        idle(); mem_resp_valid = 1'b1; #1;
        check("samecyc.count", pq_count, 0);
        check("samecyc.resp", dem_resp_valid, 1);
        step();
        mem_resp_valid = 1'b0;

        // Full queue drops, including on a cycle where the head issues.
        mem_req_ready = 1'b0;
        pf_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pf_addr = ADDR_W'(16'h0090 + k);
            exp_q.push_back(ADDR_W'(16'h0090 + k));
            step();
        end
        pf_addr = 16'h0094; #1;
        check("full.count4", pq_count, 4);
        check("full.drop", pf_drop, 1);
        step();
        mem_req_ready = 1'b1; pf_addr = 16'h0095; #1;
        check("full.drop_on_issue", pf_drop, 1);
        check_pf_issue("full.issue0");
        step();
        pf_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            check_pf_issue("full.issue");
            step();
        end

        // Tracker full: stall, then issue alongside a response.
        dem_valid = 1'b1; dem_addr = 16'h2000; #1;
        check("trk_full.no_req", mem_req_valid, 0);
        check("trk_full.no_ready", dem_ready, 0);
        step();
        mem_resp_valid = 1'b1; #1;
        check("trk_swap.req", mem_req_valid, 1);
        check("trk_swap.dem_ready", dem_ready, 1);
        check("trk_swap.fill", pf_fill, 1);
        step();
        mem_resp_valid = 1'b0; dem_addr = 16'h2001; #1;
        check("trk_swap.still_full", mem_req_valid, 0);
        step();
        dem_valid = 1'b0; mem_resp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("trk_drain.fill", pf_fill, 1);
            step();
        end
        #1;
        check("trk_drain.dem_resp", dem_resp_valid, 1);
        step();
        mem_resp_valid = 1'b0;

        // Reset with 3 outstanding and 2 queued; later responses are ignored.
        dem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dem_addr = ADDR_W'(16'h3000 + k);
            step();
        end
        dem_valid = 1'b0;
        mem_req_ready = 1'b0;
        pf_valid = 1'b1; pf_addr = 16'h00A0;
        step();
        pf_addr = 16'h00A1;
        step();
        pf_valid = 1'b0; #1;
        check("rst_mid.pq_before", pq_count, 2);
        reset = 1'b1;
        step();
        reset = 1'b0; #1;
        check_outputs_zero("rst_mid");
        mem_resp_valid = 1'b1; #1;
        check("rst_mid.no_dem_resp", dem_resp_valid, 0);
        check("rst_mid.no_fill", pf_fill, 0);
        step();
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b1; #1;
        check("rst_mid.idle", mem_req_valid, 0);
        check("exp_q.empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
